// File: rtl/terminal_stream_feeder.sv
// terminal_stream_feeder
//   Producer end of the terminal character stream. Bytes from the serial
//   receiver are buffered in a circular FIFO. They are then handed to the
//   terminal stream consumer one at a time, as a registered byte plus a
//   one-cycle strobe. Delivery is paced by the consumer's ready_n and by a
//   fixed hold-off after every byte. RTS-style flow control goes back to the
//   host with hysteresis. A dropped byte raises a sticky overflow flag.
//   Bytes are not decoded: control codes and their parameter bytes pass
//   through unchanged and in order.
//
// Handshake (consumer side): the FSM pops a byte only in S_IDLE when the FIFO
//   is non-empty and ready_n is 0. unicode_available is high for exactly the
//   one S_PRESENT cycle that follows. ready_n is then ignored for HOLDOFF
//   cycles, so the consumer's registered ready_n response is never
//   misread as a fresh "ready".
//
// Ports:
//   clk               in   system clock
//   reset_n           in   asynchronous active-low reset
//   rx_data[7:0]      in   byte from serial receiver
//   rx_valid          in   single-cycle strobe, rx_data valid
//   unicode[7:0]      out  byte presented to consumer (held until next pop)
//   unicode_available out  single-cycle strobe, unicode valid
//   ready_n           in   consumer ready, active low
//   rts_n             out  request-to-send toward host, active low
//   overflow          out  sticky: a byte was dropped on a full FIFO
//   overflow_clear    in   synchronous clear of overflow (set wins)
//   fifo_level        out  current FIFO occupancy
//   dbg_state[1:0]    out  FSM state (0 idle, 1 present, 2 holdoff)
module terminal_stream_feeder #(
  parameter int DEPTH_LOG2     = 4,
  parameter int RTS_THRESHOLD  = 12,
  parameter int RTS_HYSTERESIS = 4,
  parameter int HOLDOFF        = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            unicode,
  output logic                  unicode_available,
  input  logic                  ready_n,
  output logic                  rts_n,
  output logic                  overflow,
  input  logic                  overflow_clear,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [1:0]            dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            hold_q, hold_d;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [7:0]            unicode_q;
  logic                  rts_n_q, rts_n_d;
  logic                  overflow_q, overflow_d;

  logic full;
  logic pop;
  logic push;
  logic drop;

  assign full = (count_q == CW'(DEPTH));

  // A full FIFO still accepts a byte when the head leaves in the same cycle;
  // the freed slot is reused immediately and the count stays put.
  assign push = rx_valid && (!full || pop);
  assign drop = rx_valid && full && !pop;

  // ---------------------------------------------------------------------------
  // Delivery FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      hold_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !ready_n) begin
          pop     = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        hold_d  = 3'(HOLDOFF);
        state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        // The counter reaching zero marks the last hold-off cycle.
        hold_d = hold_q - 3'd1;
        if (hold_q <= 3'd1) begin
          hold_d  = 3'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO storage (contents need no reset: an empty count makes them dead)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output byte register: loaded on pop, held until the next pop
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      unicode_q <= 8'h00;
    end else if (pop) begin
      unicode_q <= mem_q[rd_ptr_q];
    end
  end

  // ---------------------------------------------------------------------------
  // RTS with hysteresis, decided from the next count so that it moves on the
  // same edge as the level it reacts to
  // ---------------------------------------------------------------------------
  always_comb begin
    rts_n_d = rts_n_q;
    if (count_d >= CW'(RTS_THRESHOLD)) begin
      rts_n_d = 1'b1;
    end else if (count_d <= CW'(RTS_THRESHOLD - RTS_HYSTERESIS)) begin
      rts_n_d = 1'b0;
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clear) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rts_n_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rts_n_q    <= rts_n_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign unicode           = unicode_q;
  assign unicode_available = (state_q == S_PRESENT);
  assign rts_n             = rts_n_q;
  assign overflow          = overflow_q;
  assign fifo_level        = count_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_terminal_stream_feeder.sv
module tb_terminal_stream_feeder;

  logic       clk;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] unicode;
  logic       unicode_available;
  logic       ready_n;
  logic       rts_n;
  logic       overflow;
  logic       overflow_clear;
  logic [4:0] fifo_level;
  logic [1:0] dbg_state;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic       ready_at_pe;

  terminal_stream_feeder dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .unicode           (unicode),
    .unicode_available (unicode_available),
    .ready_n           (ready_n),
    .rts_n             (rts_n),
    .overflow          (overflow),
    .overflow_clear    (overflow_clear),
    .fifo_level        (fifo_level),
    .dbg_state         (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ready_at_pe = ready_n;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at the next negedge)
  // ---------------------------------------------------------------------------
  task automatic push(input logic [7:0] b, input bit kept);
    rx_data  = b;
    rx_valid = 1'b1;
    if (kept) exp_q.push_back(b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cycles) begin
      @(negedge clk);
      c++;
    end
    check("drain_done", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    check("drain_level", fifo_level, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: every strobe must follow a ready pop edge and carry
  // the oldest expected byte.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset_n && unicode_available) begin
      check("strobe_ready_n_low", ready_at_pe, 0);
      check("strobe_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("strobe_data", unicode, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n, cyc, last, hold_cnt;
    bit raise_pending, seen;

    reset_n        = 1'b0;
    rx_data        = 8'h00;
    rx_valid       = 1'b0;
    ready_n        = 1'b0;
    overflow_clear = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_unicode", unicode, 0);
    check("rst_avail", unicode_available, 0);
    check("rst_rts", rts_n, 0);
    check("rst_ovf", overflow, 0);
    check("rst_level", fifo_level, 0);
    check("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // --- single byte latency ---
    push(8'h41, 1);
    check("lat_c1_avail", unicode_available, 0);
    check("lat_c1_level", fifo_level, 1);
    @(negedge clk);
    check("lat_c2_avail", unicode_available, 1);
    check("lat_c2_data", unicode, 8'h41);
    check("lat_c2_level", fifo_level, 0);
    @(negedge clk);
    check("lat_c3_avail", unicode_available, 0);
    check("lat_hold_data", unicode, 8'h41);
    repeat (3) @(negedge clk);

    // --- fill, rts threshold, overflow ---
    ready_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      push(8'h40 + 8'(k), 1);
      check("fill_level", fifo_level, k);
      check("fill_rts", rts_n, (k >= 12) ? 1 : 0);
    end
    push(8'h51, 0);
    check("ovf_set", overflow, 1);
    check("ovf_level", fifo_level, 16);
    overflow_clear = 1'b1;
    push(8'h52, 0);
    overflow_clear = 1'b0;
    check("ovf_set_wins", overflow, 1);
    overflow_clear = 1'b1;
    @(negedge clk);
    overflow_clear = 1'b0;
    check("ovf_clear", overflow, 0);

    // --- drain: spacing, level, rts hysteresis ---
    ready_n = 1'b0;
    n = 0; cyc = 0; last = 0;
    while (n < 16 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (unicode_available) begin
        check("drain_level_at_strobe", fifo_level, 15 - n);
        check("drain_rts", rts_n, ((15 - n) > 8) ? 1 : 0);
        if (n > 0) check("drain_spacing", cyc - last, 4);
        last = cyc;
        n++;
      end
    end
    check("drain_count", n, 16);
    wait_drain(50);

    // --- full FIFO, push coincident with pop ---
    ready_n = 1'b1;
    for (int k = 0; k < 16; k++) push(8'h60 + 8'(k), 1);
    check("full_level", fifo_level, 16);
    ready_n = 1'b0;
    push(8'h70, 1);
    check("simul_level", fifo_level, 16);
    check("simul_ovf", overflow, 0);
    wait_drain(200);

    // --- consumer pacing model ---
    ready_n = 1'b1;
    push(8'h01, 1);
    push(8'h41, 1);
    push(8'h42, 1);
    ready_n = 1'b0;
    hold_cnt = 0;
    raise_pending = 0;
    repeat (80) begin
      @(negedge clk);
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) ready_n = 1'b0;
      end else if (raise_pending) begin
        ready_n = 1'b1;
        hold_cnt = 6;
        raise_pending = 0;
      end
      if (unicode_available && unicode >= 8'h20) raise_pending = 1;
    end
    ready_n = 1'b0;
    check("consumer_all_delivered", exp_q.size(), 0);
    check("consumer_ovf", overflow, 0);

    // --- reset during S_PRESENT ---
    ready_n = 1'b1;
    push(8'h80, 1);
    for (int k = 1; k < 5; k++) push(8'h80 + 8'(k), 0);
    check("prerst_level", fifo_level, 5);
    ready_n = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (unicode_available) seen = 1;
    end
    check("prerst_strobe_seen", seen, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_avail", unicode_available, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_rts", rts_n, 0);
    check("midrst_state", dbg_state, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("postrst_level", fifo_level, 0);
    check("postrst_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/terminal_stream_feeder.md
Name: terminal_stream_feeder

Overview:
Producer end of the terminal character stream. It buffers bytes arriving from the serial receiver in a FIFO and presents them one at a time on unicode/unicode_available to the terminal stream consumer. It paces delivery using the consumer's ready_n and a fixed hold-off. It drives RTS-style flow control back toward the host and flags overflow.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).
RTS_THRESHOLD, 12, fill level at or above which rts_n is deasserted (host must stop).
RTS_HYSTERESIS, 4, rts_n re-asserts when level <= RTS_THRESHOLD - RTS_HYSTERESIS.
HOLDOFF, 2, idle cycles after each delivered byte before ready_n is sampled again (range 1..7).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rx_data  in  8  byte from serial receiver
rx_valid  in  1  single-cycle strobe, rx_data valid
unicode  out  8  byte presented to consumer
unicode_available  out  1  single-cycle strobe, unicode valid
ready_n  in  1  consumer ready, active low (0 = can accept)
rts_n  out  1  request-to-send toward host, active low (0 = send allowed)
overflow  out  1  sticky: a byte was dropped because the FIFO was full
overflow_clear  in  1  synchronous clear of overflow
fifo_level  out  DEPTH_LOG2+1  current FIFO occupancy

Behaviour:
- Reset (async, reset_n=0): FIFO empty, fifo_level=0, unicode=0, unicode_available=0, rts_n=0, overflow=0, FSM=S_IDLE.
- FIFO: circular, 2**DEPTH_LOG2 entries, pointers of DEPTH_LOG2 bits, wrap modulo depth. Count register is DEPTH_LOG2+1 bits.
- Write: on rx_valid=1, the byte is stored if the FIFO is not full, or if it is full and a pop occurs in the same cycle. In the second case the count is unchanged.
- Overflow: on rx_valid=1 with the FIFO full and no pop in that cycle, the byte is dropped and overflow is set on the next edge.
- overflow_clear=1 clears overflow. If a drop and a clear happen in the same cycle, set wins.
- Pop happens in the cycle the FSM leaves S_IDLE for S_PRESENT. Push and pop in the same cycle leave the count unchanged.
- FSM states:
  - S_IDLE: if count!=0 and ready_n=0, pop the head into unicode (registered) and go to S_PRESENT. Otherwise stay.
  - S_PRESENT: unicode_available=1 for exactly this one cycle; load holdoff counter with HOLDOFF; go to S_HOLDOFF.
  - S_HOLDOFF: unicode_available=0; decrement the counter; at 0 go to S_IDLE. ready_n is ignored in this state, which covers the consumer's one-cycle registered ready_n response.
- Latency: a byte written into an empty FIFO with ready_n=0 appears on unicode_available 2 cycles after its rx_valid edge (cycle 1 write, cycle 2 S_IDLE pop, cycle 3 strobe).
- Throughput: at most one byte per HOLDOFF+2 cycles.
- unicode holds its value after the strobe until the next pop.
- The block does not decode bytes; control codes and their parameter bytes pass through unchanged and in order.
- rts_n: set to 1 when the next count >= RTS_THRESHOLD; set to 0 when the next count <= RTS_THRESHOLD-RTS_HYSTERESIS; hold otherwise. Registered from the next count value.
- fifo_level: registered, equals count.
- Reset mid-delivery: an asynchronous assertion aborts any strobe immediately, and all FIFO contents are lost.

Test Plan:
- Reset, ready_n=0, push 0x41 -> unicode=0x41 and a one-cycle unicode_available 2 cycles after the rx_valid edge; fifo_level returns to 0.
- ready_n=1, push 0x41..0x50 (16 bytes) -> fifo_level=16 and rts_n=1 from level 12. Push 0x51 -> overflow=1, level stays 16. Set ready_n=0 -> 0x41..0x50 delivered in order, each strobe 4 cycles apart, rts_n back to 0 at level 8.
- FIFO full, ready_n=0: rx_valid in the same cycle as a pop -> byte accepted, overflow stays 0, level stays 16.
- Consumer model raises ready_n one cycle after each printable strobe and holds it high 6 cycles -> no strobe while ready_n=1; sequence 0x01,0x41,0x42 delivered with no loss.
- overflow=1, then overflow_clear with a simultaneous dropped byte -> overflow remains 1; a clean clear next cycle -> 0.
- reset_n pulsed low during S_PRESENT with 5 bytes queued -> unicode_available drops immediately, fifo_level=0, rts_n=0; no stale byte delivered afterward.
